// File: rtl/lockstep_pkg.sv
// Shared types for the lockstep commit checker: commit record, failure codes, checker states.
// Also provides the rd==0 normalisation helper used by every record comparison.
package lockstep_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] wdata;
  } commit_rec_t;

  typedef enum logic [2:0] {
    FAIL_NONE      = 3'd0,
    FAIL_MISMATCH  = 3'd1,
    FAIL_OVERFLOW  = 3'd2,
    FAIL_UNDERFLOW = 3'd3,
    FAIL_TIMEOUT   = 3'd4
  } fail_code_e;

  typedef enum logic {
    CHECK  = 1'b0,
    FAILED = 1'b1
  } chk_state_e;

  // Writes to x0 are architecturally invisible, so their data must not cause a divergence.
  function automatic commit_rec_t normalise(input commit_rec_t r);
    commit_rec_t n;
    n = r;
    if (r.rd == 5'd0) n.wdata = '0;
    return n;
  endfunction

endpackage

// File: rtl/commit_fifo.sv
// Synchronous FIFO of commit records; a pop and a push in the same cycle are legal even when full.
// The caller is responsible for never pushing into a full FIFO without a matching pop.
module commit_fifo
  import lockstep_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  commit_rec_t              din,
  output commit_rec_t              dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  commit_rec_t        r_mem [DEPTH];
  logic [AW-1:0]      r_wrPtr;
  logic [AW-1:0]      r_rdPtr;
  logic [AW:0]        r_level;

  // Storage carries no reset; only the pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wrPtr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
    end else begin
      if (push) r_wrPtr <= r_wrPtr + AW'(1);
      if (pop)  r_rdPtr <= r_rdPtr + AW'(1);
      case ({push, pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign dout  = r_mem[r_rdPtr];
  assign level = r_level;
  assign full  = (r_level == (AW+1)'(DEPTH));
  assign empty = (r_level == '0);

endmodule

// File: rtl/lockstep_commit_checker.sv
// Compares the segmented core's commit stream in order against buffered golden commits; sticky first-error report.
// Optional macro LOCKSTEP_CAPTURE_EN adds registers capturing both records of the first data mismatch.
module lockstep_commit_checker
  import lockstep_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   g_valid,
  input  logic [31:0]            g_pc,
  input  logic [4:0]             g_rd,
  input  logic [31:0]            g_wdata,
  input  logic                   s_valid,
  input  logic [31:0]            s_pc,
  input  logic [4:0]             s_rd,
  input  logic [31:0]            s_wdata,
  output logic [CNT_W-1:0]       match_count,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   fail,
  output logic [2:0]             fail_code,
  output logic [31:0]            fail_pc
`ifdef LOCKSTEP_CAPTURE_EN
  ,
  output logic [4:0]             cap_g_rd,
  output logic [31:0]            cap_g_wdata,
  output logic [4:0]             cap_s_rd,
  output logic [31:0]            cap_s_wdata
`endif
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  chk_state_e        r_state;
  chk_state_e        w_nextState;
  fail_code_e        r_failCode;
  fail_code_e        w_errCode;
  logic [31:0]       r_failPc;
  logic [31:0]       w_errPc;
  logic [CNT_W-1:0]  r_matchCount;
  logic [WD_W-1:0]   r_wdog;

  commit_rec_t       w_gRec;
  commit_rec_t       w_sRec;
  commit_rec_t       w_head;
  commit_rec_t       w_golden;
  logic              w_push;
  logic              w_pop;
  logic              w_cmpValid;
  logic              w_equal;
  logic              w_match;
  logic              w_full;
  logic              w_empty;
  logic [$clog2(DEPTH):0] w_level;

  assign w_gRec = '{pc: g_pc, rd: g_rd, wdata: g_wdata};
  assign w_sRec = '{pc: s_pc, rd: s_rd, wdata: s_wdata};

  commit_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_gRec),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .level (w_level)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= CHECK;
    else       r_state <= w_nextState;
  end

  // A segmented commit with an empty FIFO but a same-cycle golden commit compares directly (bypass).
  always_comb begin
    w_nextState = r_state;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_cmpValid  = 1'b0;
    w_golden    = w_head;
    w_errCode   = FAIL_NONE;
    w_errPc     = '0;
    w_equal     = (normalise(w_golden) == normalise(w_sRec));
    if (r_state == CHECK) begin
      if (s_valid && !w_empty) begin
        w_pop      = 1'b1;
        w_cmpValid = 1'b1;
      end else if (s_valid && g_valid) begin
        w_cmpValid = 1'b1;
        w_golden   = w_gRec;
      end
      w_equal = (normalise(w_golden) == normalise(w_sRec));
      w_push  = g_valid && !(s_valid && w_empty) && !(w_full && !w_pop);
      if (w_cmpValid && !w_equal) begin
        w_errCode = FAIL_MISMATCH;
        w_errPc   = s_pc;
      end else if (s_valid && w_empty && !g_valid) begin
        w_errCode = FAIL_UNDERFLOW;
        w_errPc   = s_pc;
      end else if (g_valid && w_full && !w_pop) begin
        w_errCode = FAIL_OVERFLOW;
        w_errPc   = g_pc;
      end else if (r_wdog >= WD_W'(TIMEOUT)) begin
        w_errCode = FAIL_TIMEOUT;
        w_errPc   = w_head.pc;
      end
      if (w_errCode != FAIL_NONE) w_nextState = FAILED;
    end
  end

  assign w_match = w_cmpValid && w_equal;

  // Counters, watchdog and error report only move while checking; FAILED freezes everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_matchCount <= '0;
      r_wdog       <= '0;
      r_failCode   <= FAIL_NONE;
      r_failPc     <= '0;
    end else if (r_state == CHECK) begin
      if (w_match && (r_matchCount != '1)) r_matchCount <= r_matchCount + CNT_W'(1);
      if (s_valid || w_empty)                 r_wdog <= '0;
      else if (r_wdog != WD_W'(TIMEOUT))      r_wdog <= r_wdog + WD_W'(1);
      if (w_errCode != FAIL_NONE) begin
        r_failCode <= w_errCode;
        r_failPc   <= w_errPc;
      end
    end
  end

`ifdef LOCKSTEP_CAPTURE_EN
  logic [4:0]  r_capGRd;
  logic [31:0] r_capGWdata;
  logic [4:0]  r_capSRd;
  logic [31:0] r_capSWdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_capGRd    <= '0;
      r_capGWdata <= '0;
      r_capSRd    <= '0;
      r_capSWdata <= '0;
    end else if ((r_state == CHECK) && (w_errCode == FAIL_MISMATCH)) begin
      r_capGRd    <= w_golden.rd;
      r_capGWdata <= w_golden.wdata;
      r_capSRd    <= s_rd;
      r_capSWdata <= s_wdata;
    end
  end

  assign cap_g_rd    = r_capGRd;
  assign cap_g_wdata = r_capGWdata;
  assign cap_s_rd    = r_capSRd;
  assign cap_s_wdata = r_capSWdata;
`endif

  assign match_count = r_matchCount;
  assign fifo_level  = w_level;
  assign fail        = (r_state == FAILED);
  assign fail_code   = r_failCode;
  assign fail_pc     = r_failPc;

endmodule

// File: tb/tb_lockstep_commit_checker.sv
// Self-checking bench for lockstep_commit_checker: directed scenarios then randomized commit streams vs a queue model.
// Build with LOCKSTEP_CAPTURE_EN defined to also check the mismatch capture outputs.
module tb_lockstep_commit_checker;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 64;
  localparam int CNT_W   = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        g_valid;
  logic [31:0] g_pc;
  logic [4:0]  g_rd;
  logic [31:0] g_wdata;
  logic        s_valid;
  logic [31:0] s_pc;
  logic [4:0]  s_rd;
  logic [31:0] s_wdata;
  logic [CNT_W-1:0]       match_count;
  logic [$clog2(DEPTH):0] fifo_level;
  logic        fail;
  logic [2:0]  fail_code;
  logic [31:0] fail_pc;
`ifdef LOCKSTEP_CAPTURE_EN
  logic [4:0]  cap_g_rd;
  logic [31:0] cap_g_wdata;
  logic [4:0]  cap_s_rd;
  logic [31:0] cap_s_wdata;
`endif

  lockstep_commit_checker #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .g_valid     (g_valid),
    .g_pc        (g_pc),
    .g_rd        (g_rd),
    .g_wdata     (g_wdata),
    .s_valid     (s_valid),
    .s_pc        (s_pc),
    .s_rd        (s_rd),
    .s_wdata     (s_wdata),
    .match_count (match_count),
    .fifo_level  (fifo_level),
    .fail        (fail),
    .fail_code   (fail_code),
    .fail_pc     (fail_pc)
`ifdef LOCKSTEP_CAPTURE_EN
    ,
    .cap_g_rd    (cap_g_rd),
    .cap_g_wdata (cap_g_wdata),
    .cap_s_rd    (cap_s_rd),
    .cap_s_wdata (cap_s_wdata)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit [31:0] pc;
    bit [4:0]  rd;
    bit [31:0] wd;
  } rec_t;

  int checks = 0;
  int errors = 0;

  // Reference model: a plain queue of outstanding golden commits plus the observable results.
  rec_t      mQ[$];
  bit [31:0] mMatch;
  bit        mFail;
  bit [2:0]  mCode;
  bit [31:0] mPc;
  int        mWdog;
  bit [4:0]  mCapGRd;
  bit [31:0] mCapGWd;
  bit [4:0]  mCapSRd;
  bit [31:0] mCapSWd;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit sameRec(input rec_t a, input rec_t b);
    bit [31:0] wa;
    bit [31:0] wb;
    wa = (a.rd == 0) ? 32'd0 : a.wd;
    wb = (b.rd == 0) ? 32'd0 : b.wd;
    return (a.pc == b.pc) && (a.rd == b.rd) && (wa == wb);
  endfunction

  function automatic void modelClear();
    mQ.delete();
    mMatch = 0; mFail = 0; mCode = 0; mPc = 0; mWdog = 0;
    mCapGRd = 0; mCapGWd = 0; mCapSRd = 0; mCapSWd = 0;
  endfunction

  function automatic void modelStep();
    rec_t      g;
    rec_t      s;
    rec_t      ref_r;
    bit        wasEmpty;
    bit        wasFull;
    bit        popped;
    bit        compared;
    bit [2:0]  code;
    bit [31:0] pc;
    bit [31:0] headPc;
    int        nextWdog;
    if (mFail) return;
    g = '{pc: g_pc, rd: g_rd, wd: g_wdata};
    s = '{pc: s_pc, rd: s_rd, wd: s_wdata};
    wasEmpty = (mQ.size() == 0);
    wasFull  = (mQ.size() == DEPTH);
    headPc   = wasEmpty ? 32'd0 : mQ[0].pc;
    popped = 0; compared = 0; code = 0; pc = 0;
    ref_r = g;
    nextWdog = (s_valid || wasEmpty) ? 0 : ((mWdog < TIMEOUT) ? mWdog + 1 : mWdog);
    if (s_valid && !wasEmpty) begin
      ref_r = mQ.pop_front();
      popped = 1; compared = 1;
    end else if (s_valid && g_valid) begin
      compared = 1;
    end
    if (compared) begin
      if (sameRec(ref_r, s)) mMatch = (mMatch == 32'hFFFF_FFFF) ? mMatch : mMatch + 1;
      else begin code = 1; pc = s_pc; end
    end
    if (code == 0 && s_valid && wasEmpty && !g_valid) begin code = 3; pc = s_pc; end
    if (g_valid && !(s_valid && wasEmpty)) begin
      if (wasFull && !popped) begin
        if (code == 0) begin code = 2; pc = g_pc; end
      end else mQ.push_back(g);
    end
    if (code == 0 && mWdog >= TIMEOUT) begin code = 4; pc = headPc; end
    if (code != 0) begin
      mFail = 1; mCode = code; mPc = pc;
      if (code == 1) begin
        mCapGRd = ref_r.rd; mCapGWd = ref_r.wd; mCapSRd = s.rd; mCapSWd = s.wd;
      end
    end
    mWdog = nextWdog;
  endfunction

  task automatic checkAll(input string tag);
    checkOutput({tag, ".match_count"}, match_count, mMatch);
    checkOutput({tag, ".fifo_level"}, 32'(fifo_level), 32'(mQ.size()));
    checkOutput({tag, ".fail"}, 32'(fail), 32'(mFail));
    checkOutput({tag, ".fail_code"}, 32'(fail_code), 32'(mCode));
    checkOutput({tag, ".fail_pc"}, fail_pc, mPc);
`ifdef LOCKSTEP_CAPTURE_EN
    checkOutput({tag, ".cap_g_rd"}, 32'(cap_g_rd), 32'(mCapGRd));
    checkOutput({tag, ".cap_g_wdata"}, cap_g_wdata, mCapGWd);
    checkOutput({tag, ".cap_s_rd"}, 32'(cap_s_rd), 32'(mCapSRd));
    checkOutput({tag, ".cap_s_wdata"}, cap_s_wdata, mCapSWd);
`endif
  endtask

  // One clock of stimulus: drive, advance the model, then sample just after the edge.
  task automatic applyStimulus(input string tag,
                               input bit gv, input bit [31:0] gpc, input bit [4:0] grd, input bit [31:0] gwd,
                               input bit sv, input bit [31:0] spc, input bit [4:0] srd, input bit [31:0] swd);
    g_valid = gv; g_pc = gpc; g_rd = grd; g_wdata = gwd;
    s_valid = sv; s_pc = spc; s_rd = srd; s_wdata = swd;
    modelStep();
    @(posedge clk);
    #1;
    checkAll(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) applyStimulus(tag, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    g_valid = 0; g_pc = 0; g_rd = 0; g_wdata = 0;
    s_valid = 0; s_pc = 0; s_rd = 0; s_wdata = 0;
    @(posedge clk);
    #1;
    modelClear();
    checkAll("reset");
    reset = 1'b0;
  endtask

  rec_t pend[$];

  initial begin
    rec_t      r;
    rec_t      sr;
    bit        gv;
    bit        sv;
    int        failHold;

    doReset();

    // Four golden commits, then the same four segmented commits later.
    for (int i = 0; i < 4; i++)
      applyStimulus("seq_g", 1, 32'(i * 4), 5'(i + 1), 32'(32'h100 + i), 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      applyStimulus("seq_s", 0, 0, 0, 0, 1, 32'(i * 4), 5'(i + 1), 32'(32'h100 + i));
    checkOutput("seq4_count", match_count, 32'd4);
    idle("seq_idle", 2);

    // Data mismatch at pc 0x08; later traffic must be ignored.
    doReset();
    applyStimulus("mm_g", 1, 32'h08, 5'd3, 32'h10, 0, 0, 0, 0);
    applyStimulus("mm_s", 0, 0, 0, 0, 1, 32'h08, 5'd3, 32'h11);
    checkOutput("mm_code", 32'(fail_code), 32'd1);
    applyStimulus("mm_after", 1, 32'h0C, 5'd4, 32'h1, 1, 32'h0C, 5'd4, 32'h1);
    idle("mm_idle", 2);

    // Nine golden commits with nothing draining them.
    doReset();
    for (int i = 0; i < 9; i++)
      applyStimulus("ovf", 1, 32'(32'h200 + i * 4), 5'd7, 32'(i), 0, 0, 0, 0);
    checkOutput("ovf_pc", fail_pc, 32'h220);
    idle("ovf_idle", 1);

    // Underflow, then a same-cycle bypass compare.
    doReset();
    applyStimulus("udf", 0, 0, 0, 0, 1, 32'h40, 5'd2, 32'h2);
    checkOutput("udf_code", 32'(fail_code), 32'd3);
    doReset();
    applyStimulus("byp", 1, 32'h44, 5'd9, 32'h99, 1, 32'h44, 5'd9, 32'h99);
    idle("byp_idle", 2);

    // Watchdog: one golden commit then silence.
    doReset();
    applyStimulus("wd_g", 1, 32'h80, 5'd1, 32'h1, 0, 0, 0, 0);
    idle("wd_idle", TIMEOUT + 4);
    checkOutput("wd_code", 32'(fail_code), 32'd4);

    // x0 writes compare with data ignored, then a mid-FAILED reset.
    doReset();
    applyStimulus("x0_g", 1, 32'h90, 5'd0, 32'd5, 0, 0, 0, 0);
    applyStimulus("x0_s", 0, 0, 0, 0, 1, 32'h90, 5'd0, 32'd9);
    applyStimulus("x0_mm", 1, 32'h94, 5'd1, 32'd5, 1, 32'h94, 5'd1, 32'd6);
    doReset();
    idle("post_rst", 1);

    // Randomized traffic: mostly matching streams with rare corruption and underflow.
    failHold = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (mFail) begin
        failHold++;
        if (failHold > 3) begin
          doReset();
          pend.delete();
          failHold = 0;
          continue;
        end
      end
      gv = ($urandom_range(0, 99) < 55);
      r.pc = $urandom;
      r.rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      r.wd = $urandom;
      sv = 0;
      sr = '{pc: 0, rd: 0, wd: 0};
      if (pend.size() > 0) begin
        sv = (pend.size() >= 6) ? ($urandom_range(0, 99) < 90) : ($urandom_range(0, 99) < 45);
        if (sv) sr = pend.pop_front();
      end else if (gv && $urandom_range(0, 99) < 30) begin
        sv = 1; sr = r;
      end else if (!gv && $urandom_range(0, 299) == 0) begin
        sv = 1; sr = r;
      end
      if (gv && !(sv && sr.pc == r.pc && pend.size() == 0 && sr.wd == r.wd)) pend.push_back(r);
      if (sv && $urandom_range(0, 149) == 0) sr.wd = sr.wd ^ 32'h1;
      applyStimulus("rand", gv, r.pc, r.rd, r.wd, sv, sr.pc, sr.rd, sr.wd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
